// File: rtl/mac_array_acc_pkg.sv
// Shared defaults, derived widths and sideband flag type for the MAC array
// accumulator and its pipelined adder tree.
package mac_array_acc_pkg;

  localparam int TIN_DEF      = 8;
  localparam int DW_DEF       = 8;
  localparam int LOG2_TIN_DEF = 3;
  localparam int ACC_W_DEF    = 32;
  localparam int CNT_W_DEF    = 16;

  // Lane product: two (DW+1)-bit extended operands -> 2*DW+2 bits signed.
  localparam int PROD_W_DEF   = 2*DW_DEF + 2;
  // Tree output grows one bit per level.
  localparam int TREE_W_DEF   = PROD_W_DEF + LOG2_TIN_DEF;

  // Sideband travelling with each beat through the pipeline.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } beat_flags_t;

  function automatic int prod_w(input int dw);
    return 2*dw + 2;
  endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Pipelined binary adder tree: N signed W-bit inputs, one register level per
// stage, LOG2N stages. Beat flags ride a shift register of matching depth.
// Nodes are heap-indexed (root 1, leaves N..2N-1) so every internal node
// registers the sum of its two children and the levels line up by depth.
module mac_adder_tree
  import mac_array_acc_pkg::*;
#(
  parameter int N     = 8,
  parameter int LOG2N = 3,
  parameter int W     = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [N-1:0][W-1:0]     in_dat,
  input  beat_flags_t             in_flg,
  output logic [W+LOG2N-1:0]      out_dat,
  output beat_flags_t             out_flg,
  output logic                    busy
);

  localparam int OW = W + LOG2N;

  // Nodes are stored at full output width; every partial sum at level j
  // fits in W+j bits, so the wider storage is value-exact.
  logic signed [OW-1:0] node  [1:2*N-1];
  logic signed [OW-1:0] sum_q [1:N-1];
  beat_flags_t [LOG2N:1] vld_pipe;

  // Leaves come straight from the registered products; internal nodes from flops.
  always_comb begin
    for (int i = 1; i < N; i++) node[i] = sum_q[i];
    for (int i = 0; i < N; i++) node[N+i] = OW'(signed'(in_dat[i]));
  end

  // One adder level per stage; data needs no reset, validity is in vld_pipe.
  always_ff @(posedge clk) begin
    for (int i = 1; i < N; i++) sum_q[i] <= node[2*i] + node[2*i+1];
  end

  // Flag shift register, flushed by clr so in-flight beats vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else if (clr) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= in_flg;
      for (int k = 2; k <= LOG2N; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // Any stage of the tree carrying a beat.
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= LOG2N; k++) busy = busy | vld_pipe[k].vld;
  end

  assign out_dat = sum_q[1];
  assign out_flg = vld_pipe[LOG2N];

endmodule

// File: rtl/mac_array_acc.sv
// TIN-lane signed/unsigned dot-product engine with temporal accumulation
// across input-channel tiles, framed by first/last flags.
// Pipeline: M (lane multiply, registered) -> T (LOG2_TIN tree levels) -> A
// (accumulate/emit). Optional build macro MAC_ACC_SAT_EN turns the
// accumulator into a saturating one and adds the sticky o_sat output.
module mac_array_acc
  import mac_array_acc_pkg::*;
#(
  parameter int TIN      = TIN_DEF,
  parameter int DW       = DW_DEF,
  parameter int LOG2_TIN = LOG2_TIN_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_vld,
  input  logic               i_first,
  input  logic               i_last,
  input  logic               i_dat_sgn,
  input  logic               i_wt_sgn,
  input  logic [DW*TIN-1:0]  i_dat,
  input  logic [DW*TIN-1:0]  i_wt,
  output logic               o_vld,
  output logic [ACC_W-1:0]   o_dat,
  output logic [CNT_W-1:0]   o_cnt,
`ifdef MAC_ACC_SAT_EN
  output logic               o_sat,
`endif
  output logic               o_busy
);

  localparam int PW = prod_w(DW);
  localparam int TW = PW + LOG2_TIN;

  if (LOG2_TIN != $clog2(TIN)) begin : g_bad_log2
    $error("mac_array_acc: LOG2_TIN must equal clog2(TIN)");
  end
  if (ACC_W < 2*DW + LOG2_TIN + 1) begin : g_bad_accw
    $error("mac_array_acc: ACC_W too narrow");
  end

  // ---------------- Stage M: per-lane extend and multiply ----------------
  logic [TIN-1:0][PW-1:0] prod_d, prod_q;
  beat_flags_t            m_flg;

  for (genvar k = 0; k < TIN; k++) begin : g_lane
    logic signed [DW:0]   a_ext, b_ext;
    logic signed [PW-1:0] a_w, b_w, p;
    assign a_ext = {i_dat_sgn & i_dat[k*DW+DW-1], i_dat[k*DW +: DW]};
    assign b_ext = {i_wt_sgn  & i_wt [k*DW+DW-1], i_wt [k*DW +: DW]};
    assign a_w   = PW'(a_ext);
    assign b_w   = PW'(b_ext);
    assign p     = a_w * b_w;
    assign prod_d[k] = p;
  end

  // Products are plain data; validity is carried in m_flg.
  always_ff @(posedge clk) prod_q <= prod_d;

  // Flags are masked by i_vld so idle-cycle garbage never enters the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) m_flg <= '0;
    else if (i_clr) m_flg <= '0;
    else m_flg <= '{vld: i_vld, first: i_vld & i_first, last: i_vld & i_last};
  end

  // ---------------- Stage T: pipelined adder tree ----------------
  logic [TW-1:0] t_sum;
  beat_flags_t   t_flg;
  logic          t_busy;

  mac_adder_tree #(.N(TIN), .LOG2N(LOG2_TIN), .W(PW)) u_tree (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_clr),
    .in_dat  (prod_q),
    .in_flg  (m_flg),
    .out_dat (t_sum),
    .out_flg (t_flg),
    .busy    (t_busy)
  );

  // ---------------- Stage A: accumulate and emit ----------------
  logic signed [ACC_W-1:0] acc, acc_base, acc_nxt, sum_ext;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    held;

  // Size cast sign-extends (or trims when ACC_W is at its minimum).
  assign sum_ext  = ACC_W'(signed'(t_sum));
  // A first beat throws away whatever partial is held.
  assign acc_base = t_flg.first ? '0 : acc;
  assign cnt_nxt  = t_flg.first ? CNT_W'(1) : ((&cnt) ? cnt : cnt + 1'b1);

`ifdef MAC_ACC_SAT_EN
  logic signed [ACC_W:0] acc_wide;
  logic                  ovf, sat_q, sat_nxt;

  assign acc_wide = (ACC_W+1)'(acc_base) + (ACC_W+1)'(sum_ext);
  // Top two bits disagree -> result left the ACC_W signed range.
  assign ovf      = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
  assign acc_nxt  = !ovf ? acc_wide[ACC_W-1:0]
                  : (acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}});
  assign sat_nxt  = (t_flg.first ? 1'b0 : sat_q) | ovf;
`else
  assign acc_nxt  = acc_base + sum_ext;
`endif

  // Accumulator, beat counter and output registers; clr beats any coincident beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      held  <= 1'b0;
      o_vld <= 1'b0;
      o_dat <= '0;
      o_cnt <= '0;
`ifdef MAC_ACC_SAT_EN
      sat_q <= 1'b0;
      o_sat <= 1'b0;
`endif
    end else if (i_clr) begin
      acc   <= '0;
      cnt   <= '0;
      held  <= 1'b0;
      o_vld <= 1'b0;
`ifdef MAC_ACC_SAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      o_vld <= 1'b0;
      if (t_flg.vld) begin
        if (t_flg.last) begin
          o_vld <= 1'b1;
          o_dat <= acc_nxt;
          o_cnt <= cnt_nxt;
          acc   <= '0;
          cnt   <= '0;
          held  <= 1'b0;
`ifdef MAC_ACC_SAT_EN
          o_sat <= sat_nxt;
          sat_q <= 1'b0;
`endif
        end else begin
          acc   <= acc_nxt;
          cnt   <= cnt_nxt;
          held  <= 1'b1;
`ifdef MAC_ACC_SAT_EN
          sat_q <= sat_nxt;
`endif
        end
      end
    end
  end

  assign o_busy = m_flg.vld | t_busy | held;

endmodule

// File: tb/tb_mac_array_acc.sv
// Bench for mac_array_acc: a table of uniform-lane framings, hand sequences
// for reset/clear/back-to-back corners, randomized traffic against a
// behavioural dot-product/accumulate model, and a small 2-lane ACC_W=18
// instance for overflow and count saturation.
module tb_mac_array_acc;

  localparam int TIN = 8, DW = 8, LOG2_TIN = 3, ACC_W = 32, CNT_W = 16;
  localparam int LAT = 2 + LOG2_TIN;
  localparam int S_TIN = 2, S_LOG2 = 1, S_ACC_W = 18, S_CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic i_clr, i_vld, i_first, i_last, i_dat_sgn, i_wt_sgn;
  logic [DW*TIN-1:0] i_dat, i_wt;
  logic o_vld, o_busy;
  logic [ACC_W-1:0] o_dat;
  logic [CNT_W-1:0] o_cnt;
  // small instance
  logic s_clr, s_vld, s_first, s_last, s_dsg, s_wsg;
  logic [DW*S_TIN-1:0] s_dat, s_wt;
  logic s_o_vld, s_o_busy;
  logic [S_ACC_W-1:0] s_o_dat;
  logic [S_CNT_W-1:0] s_o_cnt;
`ifdef MAC_ACC_SAT_EN
  logic o_sat, s_o_sat;
`endif

  mac_array_acc #(.TIN(TIN), .DW(DW), .LOG2_TIN(LOG2_TIN), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_vld(i_vld), .i_first(i_first), .i_last(i_last),
    .i_dat_sgn(i_dat_sgn), .i_wt_sgn(i_wt_sgn), .i_dat(i_dat), .i_wt(i_wt),
    .o_vld(o_vld), .o_dat(o_dat), .o_cnt(o_cnt),
`ifdef MAC_ACC_SAT_EN
    .o_sat(o_sat),
`endif
    .o_busy(o_busy));

  mac_array_acc #(.TIN(S_TIN), .DW(DW), .LOG2_TIN(S_LOG2), .ACC_W(S_ACC_W), .CNT_W(S_CNT_W)) u_small (
    .clk(clk), .rst(rst), .i_clr(s_clr), .i_vld(s_vld), .i_first(s_first), .i_last(s_last),
    .i_dat_sgn(s_dsg), .i_wt_sgn(s_wsg), .i_dat(s_dat), .i_wt(s_wt),
    .o_vld(s_o_vld), .o_dat(s_o_dat), .o_cnt(s_o_cnt),
`ifdef MAC_ACC_SAT_EN
    .o_sat(s_o_sat),
`endif
    .o_busy(s_o_busy));

  int n_tests = 0, n_fail = 0, vld_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { longint dat; longint cnt; int cyc; } exp_t;
  exp_t   exp_q[$];
  longint mdl_acc = 0, mdl_cnt = 0;

  function automatic longint lane_val(input logic [DW-1:0] v, input logic sgn);
    return sgn ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint wrap32(input longint x);
    logic [31:0] t;
    t = x[31:0];
    return longint'($signed(t));
  endfunction

  // Drive one cycle on the main instance and advance the model.
  task automatic beat(input logic clr, vld, first, last, dsg, wsg,
                      input logic [DW*TIN-1:0] d, w);
    longint s;
    i_clr = clr; i_vld = vld; i_first = first; i_last = last;
    i_dat_sgn = dsg; i_wt_sgn = wsg; i_dat = d; i_wt = w;
    if (clr) begin
      mdl_acc = 0; mdl_cnt = 0;
      // results not yet visible by the cycle after clr are lost
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= cyc + 1) exp_q.pop_back();
    end else if (vld) begin
      s = 0;
      for (int k = 0; k < TIN; k++) s += lane_val(d[k*DW +: DW], dsg) * lane_val(w[k*DW +: DW], wsg);
      if (first) begin mdl_acc = 0; mdl_cnt = 0; end
      mdl_acc = wrap32(mdl_acc + s);
      if (mdl_cnt < 65535) mdl_cnt++;
      if (last) begin
        exp_q.push_back('{dat: mdl_acc, cnt: mdl_cnt, cyc: cyc + LAT});
        mdl_acc = 0; mdl_cnt = 0;
      end
    end
    @(posedge clk); #1;
    i_clr = 1'b0; i_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      beat(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic wait_vld(input string name, output bit got);
    got = 0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (o_vld) got = 1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got no o_vld, expected a pulse", name);
    end
  endtask

  // Every emission is checked against the model: value, count and timing.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_vld) begin
      vld_seen++;
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_vld: got o_dat=%0d, expected no output", $signed(o_dat));
      end else begin
        e = exp_q.pop_front();
        chk("emit_dat", $signed(o_dat), e.dat);
        chk("emit_cnt", o_cnt, e.cnt);
        chk("emit_cyc", cyc, e.cyc);
      end
    end
  end

  // Small instance: one framing of nb identical beats, wait for the result.
  task automatic s_frame(input int nb, input logic [DW-1:0] d, w, output bit got);
    for (int b = 0; b < nb; b++) begin
      s_vld = 1'b1; s_first = (b == 0); s_last = (b == nb-1);
      s_dsg = 1'b1; s_wsg = 1'b1; s_dat = {S_TIN{d}}; s_wt = {S_TIN{w}};
      @(posedge clk); #1;
    end
    s_vld = 1'b0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (s_o_vld) got = 1;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL small_timeout: got no o_vld, expected a pulse");
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [DW-1:0] d, w;
    logic dsg, wsg;
    int nb;
    longint exp_dat, exp_cnt;
  } vec_t;
  vec_t tbl[6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit got;
    int v0;
    logic [DW*TIN-1:0] d, w;

    tbl[0] = '{8'd3,   8'hFE, 1'b1, 1'b1, 1, -48,     1};
    tbl[1] = '{8'd255, 8'd255, 1'b0, 1'b0, 4, 2080800, 4};
    tbl[2] = '{8'd200, 8'h80, 1'b0, 1'b1, 1, -204800, 1};
    tbl[3] = '{8'd200, 8'h80, 1'b1, 1'b1, 1, 57344,   1};
    tbl[4] = '{8'h80,  8'h80, 1'b1, 1'b1, 1, 131072,  1};
    tbl[5] = '{8'hFF,  8'hFF, 1'b1, 1'b0, 2, -4080,   2};

    rst = 1'b1;
    i_clr = 0; i_vld = 0; i_first = 0; i_last = 0; i_dat_sgn = 0; i_wt_sgn = 0; i_dat = '0; i_wt = '0;
    s_clr = 0; s_vld = 0; s_first = 0; s_last = 0; s_dsg = 0; s_wsg = 0; s_dat = '0; s_wt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_vld", o_vld, 0);
    chk("rst_o_dat", o_dat, 0);
    chk("rst_o_cnt", o_cnt, 0);
    chk("rst_o_busy", o_busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // table of uniform-lane framings
    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < tbl[r].nb; b++)
        beat(1'b0, 1'b1, b == 0, b == tbl[r].nb-1, tbl[r].dsg, tbl[r].wsg,
             {TIN{tbl[r].d}}, {TIN{tbl[r].w}});
      wait_vld("tbl_timeout", got);
      if (got) begin
        chk($sformatf("tbl%0d_dat", r), $signed(o_dat), tbl[r].exp_dat);
        chk($sformatf("tbl%0d_cnt", r), o_cnt, tbl[r].exp_cnt);
      end
      @(posedge clk); #1;
    end
    idle(2);
    chk("idle_busy", o_busy, 0);

    // back-to-back single-beat framings carrying 0..9
    v0 = vld_seen;
    for (int k = 0; k < 10; k++) begin
      d = '0; w = '0; d[DW-1:0] = DW'(k); w[DW-1:0] = 8'd1;
      beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, d, w);
    end
    idle(8);
    chk("b2b_pulses", vld_seen - v0, 10);
    chk("b2b_last", $signed(o_dat), 9);

    // reset with a partial held, then a fresh single beat
    d = '0; w = '0; d[DW-1:0] = 8'd7; w[DW-1:0] = 8'd1;
    beat(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, d, w);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, d, w);
    idle(7);
    chk("busy_held", o_busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_dat", o_dat, 0);
    chk("mid_rst_cnt", o_cnt, 0);
    chk("mid_rst_busy", o_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_acc = 0; mdl_cnt = 0;
    d[DW-1:0] = 8'd5;
    beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, d, w);
    idle(7);
    chk("rst_resume_dat", $signed(o_dat), 5);
    chk("rst_resume_cnt", o_cnt, 1);

    // clr with a partial held; next beat has no first so acc must be zero
    d[DW-1:0] = 8'd7;
    beat(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, d, w);
    beat(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, d, w);
    idle(7);
    beat(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("clr_keep_dat", $signed(o_dat), 5);
    chk("clr_busy", o_busy, 0);
    v0 = vld_seen;
    d[DW-1:0] = 8'd5;
    beat(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, d, w);
    idle(7);
    chk("clr_resume_pulse", vld_seen - v0, 1);
    chk("clr_resume_cnt", o_cnt, 1);

    // clr kills an in-flight beat and a coincident one
    v0 = vld_seen;
    d[DW-1:0] = 8'd9;
    beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, d, w);
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, d, w);
    idle(8);
    chk("clr_inflight", vld_seen - v0, 0);

    // first discards a held partial; a later beat without first starts from 0
    d[DW-1:0] = 8'd100;
    beat(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, d, w);
    d[DW-1:0] = 8'd3;
    beat(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, d, w);
    d[DW-1:0] = 8'd4;
    beat(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, d, w);
    idle(7);
    chk("implicit_first_dat", $signed(o_dat), 4);
    chk("implicit_first_cnt", o_cnt, 1);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      beat(1'($urandom_range(49) == 0), 1'($urandom_range(3) != 0),
           1'($urandom_range(4) == 0), 1'($urandom_range(3) == 0),
           1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    beat(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    idle(10);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_busy", o_busy, 0);

    // small instance: overflow of 5 x 32258 in 18 bits
    s_frame(5, 8'd127, 8'd127, got);
`ifdef MAC_ACC_SAT_EN
    chk("small_sat_dat", $signed(s_o_dat), 131071);
    chk("small_sat_flag", s_o_sat, 1);
`else
    chk("small_wrap_dat", $signed(s_o_dat), -100854);
`endif
    chk("small_cnt5", s_o_cnt, 5);
    // beat count saturates at 2^3-1
    s_frame(9, 8'd1, 8'd1, got);
    chk("small_cntsat_dat", $signed(s_o_dat), 18);
    chk("small_cntsat_cnt", s_o_cnt, 7);
`ifdef MAC_ACC_SAT_EN
    chk("small_nosat_flag", s_o_sat, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_array_acc.md
Name: mac_array_acc

Overview:
- Parametrised successor to the single-cycle Tin-lane MAC array: TIN-lane signed/unsigned dot-product engine.
- Registered multiply stage, fully pipelined adder tree, and a temporal accumulator that sums dot products across consecutive input-channel tiles.
- Framing is controlled by first/last flags.
- Sits between the feature/weight buffers and the output quantiser of the CNN datapath; one instance per output channel.

Parameters:
- TIN, 8, number of lanes (power of two, ≥2).
- DW, 8, operand width per lane.
- LOG2_TIN, 3, log2(TIN); must equal $clog2(TIN).
- ACC_W, 32, accumulator/output width; must be ≥ 2*DW+LOG2_TIN+1.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_clr  in  1  synchronous flush of pipeline valids, accumulator and counter.
- i_vld  in  1  input beat valid.
- i_first  in  1  beat starts a new accumulation (qualified by i_vld).
- i_last  in  1  beat ends the accumulation (qualified by i_vld).
- i_dat_sgn  in  1  1: dat lanes signed, 0: unsigned; sampled per beat.
- i_wt_sgn  in  1  1: wt lanes signed, 0: unsigned; sampled per beat.
- i_dat  in  DW*TIN  lane k at [k*DW +: DW].
- i_wt  in  DW*TIN  lane k at [k*DW +: DW].
- o_vld  out  1  one-cycle pulse, accumulation result valid.
- o_dat  out  ACC_W  signed accumulated result.
- o_cnt  out  CNT_W  number of beats in the emitted accumulation.
- o_busy  out  1  any beat in flight or partial accumulation held.

Behaviour:
- Reset (async, rst=1): all pipeline valids, flags, accumulator, counter, o_vld, o_dat, o_cnt and o_busy go to 0.
  - Reset mid-accumulation discards the partial sum; no output is produced for it.
- Stage M (1 cycle): each lane extends its operands to DW+1 bits (sign-extend if the respective sgn bit is 1, else zero-extend), then forms a signed (2*DW+2)-bit product.
  - Products are registered; i_first/i_last/i_vld travel alongside.
- Stage T (LOG2_TIN cycles): binary adder tree, one registered level per cycle. Level j is (2*DW+2+j) bits wide, sign-extended. Flags are delayed to match.
- Stage A (1 cycle): tree sum sign-extended to ACC_W.
  - On a valid beat: acc <= first ? sum : acc + sum; cnt <= first ? 1 : cnt+1.
  - Wrap-around arithmetic modulo 2^ACC_W.
  - cnt saturates at 2^CNT_W-1.
- Output: on a valid beat with last, o_dat <= new acc value, o_cnt <= new cnt and o_vld pulses for 1 cycle; acc and cnt are then cleared to 0.
  - o_dat and o_cnt hold until the next emission.
- Latency: i_vld&i_last at cycle t gives o_vld at t+2+LOG2_TIN (t+5 for TIN=8). Throughput is 1 beat/cycle with no stall.
- Boundary conditions:
  - first&last on the same beat: emits that beat's dot product alone, cnt=1.
  - Beat without first after an emission: accumulates onto 0 (acc cleared), so it behaves as an implicit first.
  - first while a partial accumulation is held: the partial is discarded silently and the new sum is loaded.
  - i_vld=0 cycles inside an accumulation: the accumulator holds its value.
  - i_clr=1: all in-flight beats are dropped, acc/cnt are zeroed and o_vld is forced to 0 that cycle. o_dat/o_cnt keep their last values. i_clr has priority over a coincident input beat.
  - Flags and sgn bits are ignored when i_vld=0.
- o_busy = OR of pipeline valids | (acc-held flag set by a non-last beat, cleared by last/clr/rst).

Optional Feature:
- MAC_ACC_SAT_EN: when defined, Stage A computes acc+sum at ACC_W+1 bits and clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A sticky o_sat port (1 bit, reset 0) is added; it is set when any clamp occurs within the current accumulation and is emitted/cleared with o_vld.
- When MAC_ACC_SAT_EN is undefined: wrap-around arithmetic and no o_sat port.

Decomposition:
- Shared package/header holds TIN, DW, LOG2_TIN, ACC_W defaults and the derived product width 2*DW+2 and tree width 2*DW+2+LOG2_TIN.
- One natural sub-module, mac_adder_tree: parametrised pipelined tree (inputs TIN×W, one register level per stage, sideband flag pipeline of matching depth). Multiply and accumulate stages stay in the top.

Test Plan (TIN=8, DW=8, ACC_W=32):
- All lanes dat=3, wt=-2, signed, first&last on one beat -> o_vld at t+5, o_dat=-48, o_cnt=1.
- Unsigned both: dat=255, wt=255 on all lanes, 4 beats (first on beat 0, last on beat 3) -> single o_vld, o_dat=2080800, o_cnt=4.
- Mixed: dat unsigned 200, wt signed -128 on all lanes -> o_dat=-204800; same bits with dat signed -> o_dat=57344.
- Back-to-back framings, every beat first&last, 10 consecutive cycles with lane0 dat=k, wt=1 and other lanes 0 -> 10 consecutive o_vld pulses carrying 0..9.
- Assert rst while 2 of 3 beats are accumulated, then send one first&last beat (sum 5) -> no stale output, o_dat=5, o_cnt=1. Repeat with i_clr instead of rst -> same result.
- With MAC_ACC_SAT_EN, ACC_W=18: accumulate 5 beats of dot product 32258 (each lane 127*127, signed) -> o_dat=131071, o_sat=1. Without the macro -> o_dat equals the modulo-2^18 wrapped value (161290-262144=-100854).
